// File: rtl/id_ex_ctrl_slice_pkg.sv
// Shared constants and types for the ID/EX control slice (package id_ex_pkg).
package id_ex_pkg;
  localparam int ADDR_W = 32;
  localparam int CTRL_W = 17;
  localparam int PC_INC = 4;

  typedef logic [CTRL_W-1:0] ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;
endpackage

// File: rtl/id_ex_ctrl_slice_bubble_mux.sv
// ID-stage bubble mux: passes the decoded control word when s_i is 0, otherwise a NOP word.
import id_ex_pkg::*;

module ctrl_bubble_mux #(
  parameter int W = CTRL_W
) (
  input  logic [W-1:0] ctrl_i,
  input  logic         s_i,
  output logic [W-1:0] ctrl_o
);

  // Only an explicit 0 selects the live word, so an unknown select falls through to NOP.
  always_comb begin
    ctrl_o = '0;
    if (s_i == 1'b0) begin
      ctrl_o = ctrl_i;
    end
  end

endmodule

// File: rtl/id_ex_ctrl_slice.sv
// Front-to-EX control slice: PC+INC adder, ID bubble mux and the ID/EX control register.
// Defining ID_EX_HOLD_EN adds the ex_le load enable on the EX register.
import id_ex_pkg::*;

module id_ex_ctrl_slice #(
  parameter int ADDR_W = id_ex_pkg::ADDR_W,
  parameter int CTRL_W = id_ex_pkg::CTRL_W,
  parameter int INC    = id_ex_pkg::PC_INC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adder_in,
  output logic [ADDR_W-1:0] adder_out,
  input  logic [CTRL_W-1:0] control_signals_in,
  input  logic              S,
  output logic [CTRL_W-1:0] mux_control_signals,
  output logic [CTRL_W-1:0] control_signals_out
`ifdef ID_EX_HOLD_EN
  ,
  input  logic              ex_le
`endif
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [CTRL_W-1:0] ctrl_d;

  // Carry out of the top bit is dropped, giving the natural wrap of the PC.
  assign adder_out = adder_in + ADDR_W'(INC);

  ctrl_bubble_mux #(
    .W (CTRL_W)
  ) u_bubble_mux (
    .ctrl_i (control_signals_in),
    .s_i    (S),
    .ctrl_o (mux_control_signals)
  );

  always_comb begin
    ctrl_d = ctrl_q;
`ifdef ID_EX_HOLD_EN
    if (ex_le) begin
      ctrl_d = mux_control_signals;
    end
`else
    ctrl_d = mux_control_signals;
`endif
  end

  // Reset is asynchronous and wins over a coincident clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign control_signals_out = ctrl_q;

endmodule

// File: tb/tb_id_ex_ctrl_slice.sv
// Self-checking bench for id_ex_ctrl_slice: directed cases followed by randomized cycles
// compared against a cycle-level reference of what EX should hold.
module tb_id_ex_ctrl_slice;

  localparam int AW = 32;
  localparam int CW = 17;

  logic          clk;
  logic          reset;
  logic [AW-1:0] adder_in;
  logic [AW-1:0] adder_out;
  logic [CW-1:0] control_signals_in;
  logic          S;
  logic [CW-1:0] mux_control_signals;
  logic [CW-1:0] control_signals_out;
`ifdef ID_EX_HOLD_EN
  logic          ex_le;
`endif

  int checks;
  int failures;

  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] ex_model;

  id_ex_ctrl_slice dut (
    .clk                 (clk),
    .reset               (reset),
    .adder_in            (adder_in),
    .adder_out           (adder_out),
    .control_signals_in  (control_signals_in),
    .S                   (S),
    .mux_control_signals (mux_control_signals),
    .control_signals_out (control_signals_out)
`ifdef ID_EX_HOLD_EN
    ,
    .ex_le               (ex_le)
`endif
  );

  // Clock: period 4, posedges at t=2,6,10,...
  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_pc_inc(input logic [31:0] a);
    longint unsigned wide;
    wide = (longint'(a) + 64'd4) % 64'h1_0000_0000;
    return wide[31:0];
  endfunction

  function automatic logic [CW-1:0] ref_mux(input logic sel, input logic [CW-1:0] w);
    return sel ? '0 : w;
  endfunction

  initial begin
    logic [CW-1:0] word;
    logic          le;
    checks   = 0;
    failures = 0;

    // Reset asserted from time zero
    reset              = 1'b0;
    S                  = 1'b0;
    control_signals_in = 17'h00001;
    adder_in           = 32'h0000_0000;
`ifdef ID_EX_HOLD_EN
    ex_le              = 1'b1;
`endif
    #1;
    check_eq("reset_out", 32'(control_signals_out), 32'h0);
    check_eq("adder_0", adder_out, 32'h0000_0004);
    adder_in = 32'hFFFF_FFFC;
    #2;
    check_eq("adder_wrap", adder_out, 32'h0000_0000);
    check_eq("reset_hold_clk", 32'(control_signals_out), 32'h0);
    adder_in = 32'h0000_0010;
    reset    = 1'b1;   // release at t=3
    @(posedge clk); #1;
    check_eq("release_load", 32'(control_signals_out), 32'h00001);
    check_eq("adder_0x10", adder_out, 32'h0000_0014);

    // Pass-through
    S = 1'b0; control_signals_in = 17'h1A5A5;
    #1;
    check_eq("mux_pass", 32'(mux_control_signals), 32'h1A5A5);
    @(posedge clk); #1;
    check_eq("ex_pass", 32'(control_signals_out), 32'h1A5A5);

    // Bubble
    S = 1'b1; control_signals_in = 17'h1FFFF;
    #1;
    check_eq("mux_bubble", 32'(mux_control_signals), 32'h0);
    @(posedge clk); #1;
    check_eq("ex_bubble", 32'(control_signals_out), 32'h0);
    S = 1'b0;
    #1;
    check_eq("mux_unbubble", 32'(mux_control_signals), 32'h1FFFF);
    check_eq("ex_before_edge", 32'(control_signals_out), 32'h0);
    @(posedge clk); #1;
    check_eq("ex_unbubble", 32'(control_signals_out), 32'h1FFFF);

    // Async reset mid-cycle
    control_signals_in = 17'h0F0F0;
    @(posedge clk); #1;
    check_eq("ex_0f0f0", 32'(control_signals_out), 32'h0F0F0);
    reset = 1'b0;
    #1;
    check_eq("async_clear", 32'(control_signals_out), 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_eq("reset_low_clk", 32'(control_signals_out), 32'h0);
    end
    reset = 1'b1;
    control_signals_in = 17'h00123;
    @(posedge clk); #1;
    check_eq("after_reset", 32'(control_signals_out), 32'h00123);
    ex_model = 17'h00123;

`ifdef ID_EX_HOLD_EN
    control_signals_in = 17'h00ABC; ex_le = 1'b1;
    @(posedge clk); #1;
    check_eq("hold_load", 32'(control_signals_out), 32'h00ABC);
    ex_le = 1'b0;
    for (int i = 0; i < 3; i++) begin
      control_signals_in = CW'($urandom);
      @(posedge clk); #1;
      check_eq("hold_keep", 32'(control_signals_out), 32'h00ABC);
    end
    ex_le = 1'b1; control_signals_in = 17'h00155;
    @(posedge clk); #1;
    check_eq("hold_release", 32'(control_signals_out), 32'h00155);
    ex_model = 17'h00155;
`endif

    // Randomized cycles; only the values present at the posedge matter for EX
    for (int n = 0; n < 300; n++) begin
      word = CW'($urandom);
      control_signals_in = word;
      S = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) adder_in = 32'hFFFF_FFF8 + $urandom_range(0, 7);
      else adder_in = $urandom;
      le = 1'b1;
`ifdef ID_EX_HOLD_EN
      le = ($urandom_range(0, 3) != 0);
      ex_le = le;
`endif
      #1;
      check_eq("rnd_mux", 32'(mux_control_signals), 32'(ref_mux(S, word)));
      check_eq("rnd_adder", adder_out, ref_pc_inc(adder_in));
      if ($urandom_range(0, 3) == 0) begin
        S = ~S;   // mid-cycle glitch; the final value is what gets sampled
        #1;
        check_eq("rnd_mux_glitch", 32'(mux_control_signals), 32'(ref_mux(S, word)));
      end
      if (le) ex_model = ref_mux(S, word);
      exp_q.push_back(ex_model);
      @(posedge clk); #1;
      check_eq("rnd_ex", 32'(control_signals_out), 32'(exp_q.pop_front()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
